// File: rtl/alu_mc_ctrl.sv
// Multicycle control FSM for the MIPS-subset datapath: drives ALU control, operand
// selects and write strobes, resolves beq from ZF, and times out stalled memory accesses.
module alu_mc_ctrl #(
    parameter int TIMEOUT = 0,
    parameter int TO_W    = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       ZF,
    input  logic       MemReady,
    output logic [2:0] ALUCtl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic [1:0] PCSrc,
    output logic       IllegalOp,
    output logic       BusErr,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        BEQ_EX   = 4'd8,
        ADDI_EX  = 4'd9,
        ADDI_WB  = 4'd10,
        J_EX     = 4'd11
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOP = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    state_t          state, state_nxt;
    logic [TO_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [5:0]      functq;
    logic            in_wait;
    logic            timeout;
    logic [3:0]      rdec;

    // Returns {illegal, alu_ctl} for a captured R-type funct field.
    function automatic logic [3:0] rtype_decode(input logic [5:0] f);
        case (f)
            6'b100000: rtype_decode = {1'b0, ALU_ADD};
            6'b100010: rtype_decode = {1'b0, ALU_SUB};
            6'b100100: rtype_decode = {1'b0, ALU_AND};
            6'b100101: rtype_decode = {1'b0, ALU_OR};
            6'b101010: rtype_decode = {1'b0, ALU_SLT};
            6'b000000: rtype_decode = {1'b0, ALU_NOP};
            default:   rtype_decode = {1'b1, ALU_NOP};
        endcase
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= FETCH;
            wait_cnt <= '0;
            functq   <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state == DECODE)
                functq <= Funct;
        end
    end

    assign rdec    = rtype_decode(functq);
    assign in_wait = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    // MemReady in the limit cycle still completes the access normally.
    assign timeout = (TIMEOUT != 0) && in_wait && !MemReady && (wait_cnt == TO_LIM);

    always_comb begin
        wait_cnt_nxt = '0;
        if (in_wait && !MemReady && !timeout)
            wait_cnt_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + TO_W'(1);
    end

    always_comb begin
        state_nxt = state;
        ALUCtl    = ALU_NOP;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        RegDst    = 1'b0;
        MemToReg  = 1'b0;
        PCSrc     = 2'b00;
        IllegalOp = 1'b0;
        BusErr    = 1'b0;

        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUCtl  = ALU_ADD;
                if (MemReady) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                ALUCtl  = ALU_ADD;
                case (Opcode)
                    6'b000000:            state_nxt = RTYPE_EX;
                    6'b100011, 6'b101011: state_nxt = MEMADR;
                    6'b000100:            state_nxt = BEQ_EX;
                    6'b001000:            state_nxt = ADDI_EX;
                    6'b000010:            state_nxt = J_EX;
                    default: begin
                        IllegalOp = 1'b1;
                        state_nxt = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ALUCtl    = ALU_ADD;
                state_nxt = (Opcode == 6'b100011) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady)
                    state_nxt = MEMWB;
            end
            MEMWB: begin
                RegWrite  = 1'b1;
                MemToReg  = 1'b1;
                state_nxt = FETCH;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady)
                    state_nxt = FETCH;
            end
            RTYPE_EX: begin
                ALUSrcA   = 1'b1;
                ALUCtl    = rdec[2:0];
                IllegalOp = rdec[3];
                state_nxt = RTYPE_WB;
            end
            RTYPE_WB: begin
                RegDst    = 1'b1;
                RegWrite  = !rdec[3] && (functq != 6'b000000);
                state_nxt = FETCH;
            end
            BEQ_EX: begin
                ALUSrcA   = 1'b1;
                ALUCtl    = ALU_SUB;
                PCSrc     = 2'b01;
                PCWrite   = ZF;
                state_nxt = FETCH;
            end
            ADDI_EX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ALUCtl    = ALU_ADD;
                state_nxt = ADDI_WB;
            end
            ADDI_WB: begin
                RegWrite  = 1'b1;
                state_nxt = FETCH;
            end
            J_EX: begin
                PCSrc     = 2'b10;
                PCWrite   = 1'b1;
                state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase

        // A timed-out access is abandoned silently apart from the BusErr pulse.
        if (timeout) begin
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            BusErr    = 1'b1;
            state_nxt = FETCH;
        end

        if (RST) begin
            ALUCtl    = ALU_NOP;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 2'b00;
            IorD      = 1'b0;
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            RegWrite  = 1'b0;
            RegDst    = 1'b0;
            MemToReg  = 1'b0;
            PCSrc     = 2'b00;
            IllegalOp = 1'b0;
            BusErr    = 1'b0;
        end
    end

    assign State = state;

endmodule

// File: tb/tb_alu_mc_ctrl.sv
// Directed bench for alu_mc_ctrl: one instance with TIMEOUT=5 and one with the timeout
// disabled, both fed the same instruction stream and checked against hand-derived values.
module tb_alu_mc_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       ZF;
    logic       MemReady;

    logic [2:0] ALUCtl_a, ALUCtl_b;
    logic       ALUSrcA_a, ALUSrcA_b;
    logic [1:0] ALUSrcB_a, ALUSrcB_b;
    logic       IorD_a, IorD_b;
    logic       MemRead_a, MemRead_b, MemWrite_a, MemWrite_b;
    logic       IRWrite_a, IRWrite_b, PCWrite_a, PCWrite_b, RegWrite_a, RegWrite_b;
    logic       RegDst_a, RegDst_b, MemToReg_a, MemToReg_b;
    logic [1:0] PCSrc_a, PCSrc_b;
    logic       IllegalOp_a, IllegalOp_b, BusErr_a, BusErr_b;
    logic [3:0] State_a, State_b;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    alu_mc_ctrl #(.TIMEOUT(5), .TO_W(8)) dut_a (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .ZF(ZF), .MemReady(MemReady),
        .ALUCtl(ALUCtl_a), .ALUSrcA(ALUSrcA_a), .ALUSrcB(ALUSrcB_a), .IorD(IorD_a),
        .MemRead(MemRead_a), .MemWrite(MemWrite_a), .IRWrite(IRWrite_a), .PCWrite(PCWrite_a),
        .RegWrite(RegWrite_a), .RegDst(RegDst_a), .MemToReg(MemToReg_a), .PCSrc(PCSrc_a),
        .IllegalOp(IllegalOp_a), .BusErr(BusErr_a), .State(State_a)
    );

    alu_mc_ctrl #(.TIMEOUT(0), .TO_W(8)) dut_b (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .ZF(ZF), .MemReady(MemReady),
        .ALUCtl(ALUCtl_b), .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .IorD(IorD_b),
        .MemRead(MemRead_b), .MemWrite(MemWrite_b), .IRWrite(IRWrite_b), .PCWrite(PCWrite_b),
        .RegWrite(RegWrite_b), .RegDst(RegDst_b), .MemToReg(MemToReg_b), .PCSrc(PCSrc_b),
        .IllegalOp(IllegalOp_b), .BusErr(BusErr_b), .State(State_b)
    );

    // Strobe bundles, MSB to LSB: MemRead MemWrite IRWrite PCWrite RegWrite
    wire [4:0] stb_a = {MemRead_a, MemWrite_a, IRWrite_a, PCWrite_a, RegWrite_a};
    wire [4:0] stb_b = {MemRead_b, MemWrite_b, IRWrite_b, PCWrite_b, RegWrite_b};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; Opcode = 6'b100011; Funct = 6'b000000; ZF = 1'b0; MemReady = 1'b1;
        #2;
        chk("rst_state",  8'(State_a), 8'd0);
        chk("rst_stb",    8'(stb_a), 8'h00);
        chk("rst_alu",    8'(ALUCtl_a), 8'd3);
        chk("rst_misc",   8'({IorD_a, ALUSrcB_a, IllegalOp_a, BusErr_a}), 8'h00);

        // Release, walk lw into MEMRD, then reset in the middle of the access
        tick(); RST = 1'b0; #1;
        chk("rel_stb",    8'(stb_a), 8'b10110);
        tick(); tick(); tick(); MemReady = 1'b0; #1;
        chk("memrd_state", 8'(State_a), 8'd3);
        chk("memrd_stb",   8'(stb_a), 8'b10000);
        chk("memrd_iord",  8'(IorD_a), 8'd1);
        RST = 1'b1; #1;
        chk("midrst_state", 8'(State_a), 8'd0);
        chk("midrst_stb",   8'(stb_a), 8'h00);
        chk("midrst_alu",   8'(ALUCtl_a), 8'd3);
        chk("midrst_iord",  8'(IorD_a), 8'd0);
        tick(); RST = 1'b0; MemReady = 1'b1; Opcode = 6'b000000; Funct = 6'b100010; #1;
        chk("post_fetch_state", 8'(State_a), 8'd0);
        chk("post_fetch_stb",   8'(stb_a), 8'b10110);
        chk("post_fetch_alu",   8'({ALUCtl_a, ALUSrcA_a, ALUSrcB_a}), {2'b0, 3'b010, 1'b0, 2'b01});

        // R-type sub: FETCH, DECODE, RTYPE_EX, RTYPE_WB
        tick();
        chk("rt_dec_state", 8'(State_a), 8'd1);
        chk("rt_dec_sel",   8'({ALUSrcA_a, ALUSrcB_a, ALUCtl_a}), {3'b0, 1'b0, 2'b11, 3'b010});
        chk("rt_dec_stb",   8'(stb_a), 8'h00);
        tick();
        chk("rt_ex_state",  8'(State_a), 8'd6);
        chk("rt_ex_alu",    8'(ALUCtl_a), 8'b110);
        chk("rt_ex_sel",    8'({ALUSrcA_a, ALUSrcB_a}), 8'b100);
        chk("rt_ex_stb",    8'(stb_a), 8'h00);
        tick();
        chk("rt_wb_state",  8'(State_a), 8'd7);
        chk("rt_wb_stb",    8'(stb_a), 8'b00001);
        chk("rt_wb_dst",    8'({RegDst_a, MemToReg_a}), 8'b10);
        tick();
        chk("rt_done",      8'(State_a), 8'd0);

        // beq taken then not taken
        Opcode = 6'b000100; ZF = 1'b1;
        tick(); tick();
        chk("beq1_state",   8'(State_a), 8'd8);
        chk("beq1_alu",     8'({ALUCtl_a, PCSrc_a}), {3'b0, 3'b110, 2'b01});
        chk("beq1_stb",     8'(stb_a), 8'b00010);
        tick();
        chk("beq1_done",    8'(State_a), 8'd0);
        ZF = 1'b0;
        tick(); tick();
        chk("beq0_state",   8'(State_a), 8'd8);
        chk("beq0_alu",     8'({ALUCtl_a, PCSrc_a}), {3'b0, 3'b110, 2'b01});
        chk("beq0_stb",     8'(stb_a), 8'h00);
        tick();
        chk("beq0_done",    8'(State_a), 8'd0);

        // lw with three stalled MEMRD cycles on the timeout-disabled instance
        Opcode = 6'b100011;
        tick();
        chk("lw_memadr",    8'({State_b, ALUSrcA_b, ALUSrcB_b}), {1'b0, 4'd1, 1'b0, 2'b11});
        tick();
        chk("lw_adr_sel",   8'({State_b, ALUSrcA_b, ALUSrcB_b}), {1'b0, 4'd2, 1'b1, 2'b10});
        tick(); MemReady = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lw_wait%0d", i), 8'({State_b, stb_b[4], BusErr_b}), {2'b0, 4'd3, 1'b1, 1'b0});
            tick();
        end
        MemReady = 1'b1; #1;
        chk("lw_wait3",     8'({State_b, stb_b[4]}), {3'b0, 4'd3, 1'b1});
        tick();
        chk("lw_wb_state",  8'(State_b), 8'd4);
        chk("lw_wb_stb",    8'(stb_b), 8'b00001);
        chk("lw_wb_sel",    8'({RegDst_b, MemToReg_b}), 8'b01);
        chk("lw_wb_a",      8'(State_a), 8'd4);
        tick();
        chk("lw_done",      8'(State_b), 8'd0);

        // MemReady stuck low in FETCH: BusErr on the 6th cycle of TIMEOUT=5 instance only
        MemReady = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("to_wait%0d", i), 8'({State_a, BusErr_a, stb_a[2]}), 8'h00);
            tick();
        end
        chk("to_buserr",    8'(BusErr_a), 8'd1);
        chk("to_stb",       8'(stb_a), 8'h00);
        chk("to_b_quiet",   8'({BusErr_b, stb_b}), 8'b010000);
        tick();
        chk("to_refetch",   8'({State_a, BusErr_a, stb_a}), 8'b10000);
        chk("to_b_state",   8'({State_b, BusErr_b}), 8'd0);
        tick(); tick(); tick();
        chk("to_b_still",   8'(BusErr_b), 8'd0);
        chk("to_a_cnt_rst", 8'(BusErr_a), 8'd0);
        tick(); tick();
        chk("to_b_noerr",   8'(BusErr_b), 8'd0);
        chk("to_a_again",   8'(BusErr_a), 8'd1);

        // Realign both instances on a fresh FETCH
        RST = 1'b1; tick(); RST = 1'b0; MemReady = 1'b1;

        // Illegal opcode
        Opcode = 6'b111111;
        tick();
        chk("ill_dec",      8'({State_a, IllegalOp_a}), {3'b0, 4'd1, 1'b1});
        chk("ill_stb",      8'(stb_a), 8'h00);
        tick();
        chk("ill_done",     8'({State_a, IllegalOp_a}), 8'h00);

        // Illegal funct in R-type
        Opcode = 6'b000000; Funct = 6'b000111;
        tick();
        chk("ifn_dec",      8'(IllegalOp_a), 8'd0);
        tick();
        chk("ifn_ex",       8'({State_a, ALUCtl_a, IllegalOp_a}), {4'd6, 3'b011, 1'b1});
        tick();
        chk("ifn_wb",       8'({State_a, RegDst_a, stb_a[0]}), {2'b0, 4'd7, 1'b1, 1'b0});
        tick();
        chk("ifn_done",     8'(State_a), 8'd0);

        // sw and j
        Opcode = 6'b101011;
        tick(); tick(); tick();
        chk("sw_memwr",     8'({State_a, IorD_a}), {3'b0, 4'd5, 1'b1});
        chk("sw_stb",       8'(stb_a), 8'b01000);
        tick();
        chk("sw_done",      8'(State_a), 8'd0);
        Opcode = 6'b000010;
        tick(); tick();
        chk("j_ex",         8'({State_a, PCSrc_a}), {2'b0, 4'd11, 2'b10});
        chk("j_stb",        8'(stb_a), 8'b00010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
